// File: rtl/counter_monitor.sv
// counter_monitor
// ----------------
// On-chip self-checker for a WIDTH-bit up-counter. Each cycle it samples the
// counter value together with the enable that drives it. It then checks that
// the value advanced by exactly the enable sampled on the previous edge,
// modulo 2^WIDTH. After LOCK_CNT consecutive good steps it reports lock.
// A mismatch while locked raises a one-cycle error pulse and bumps a
// saturating error counter. Verified max->0 wraps seen while locked are
// counted in a free-running wrap counter.
//
// Ports
//   clock_i          system clock, all state updates on the rising edge
//   reset_i          synchronous active-high reset, discards all history
//   enable_i         enable seen by the monitored counter
//   counter_value_i  monitored counter value (WIDTH bits)
//   clear_i          synchronous clear of error_count_o and wrap_count_o only
//   locked_o         high while the monitor is locked
//   error_o          one-cycle pulse on a mismatch detected while locked
//   error_count_o    locked mismatches, saturating at all-ones (CNT_W bits)
//   wrap_count_o     verified wraps, wrapping modulo 2^CNT_W (CNT_W bits)
//
// All outputs are registered; there is no combinational input->output path.

module counter_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] counter_value_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             error_o,
    output logic [CNT_W-1:0] error_count_o,
    output logic [CNT_W-1:0] wrap_count_o
);

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] VAL_MAX     = {WIDTH{1'b1}};

    state_t             state_r;
    state_t             state_next_s;
    logic [3:0]         match_r;
    logic [3:0]         match_next_s;
    logic [WIDTH-1:0]   prev_r;
    logic               prev_en_r;
    logic               locked_r;
    logic               error_r;
    logic [CNT_W-1:0]   error_count_r;
    logic [CNT_W-1:0]   wrap_count_r;

    logic [WIDTH-1:0]   expected_s;
    logic               hit_s;
    logic               error_event_s;
    logic               wrap_event_s;
    logic [CNT_W-1:0]   error_count_next_s;
    logic [CNT_W-1:0]   wrap_count_next_s;

    // The counter should have moved by exactly the enable it saw last edge.
    assign expected_s = prev_r + WIDTH'(prev_en_r);
    assign hit_s      = (counter_value_i == expected_s);

    // State and consecutive-match counter register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r <= ST_UNSYNC;
            match_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            match_r <= match_next_s;
        end
    end

    // Next-state logic: acquire lock on a run of hits, drop it on a miss
    always_comb begin
        state_next_s = state_r;
        match_next_s = match_r;
        case (state_r)
            ST_UNSYNC: begin
                // First edge after reset only captures history.
                state_next_s = ST_ACQUIRE;
                match_next_s = 4'd0;
            end
            ST_ACQUIRE: begin
                if (hit_s) begin
                    if ((match_r + 4'd1) == LOCK_TARGET) begin
                        state_next_s = ST_LOCKED;
                        match_next_s = 4'd0;
                    end else begin
                        state_next_s = ST_ACQUIRE;
                        match_next_s = match_r + 4'd1;
                    end
                end else begin
                    state_next_s = ST_ACQUIRE;
                    match_next_s = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (hit_s) begin
                    state_next_s = ST_LOCKED;
                    match_next_s = 4'd0;
                end else begin
                    state_next_s = ST_ACQUIRE;
                    match_next_s = 4'd0;
                end
            end
            default: begin
                state_next_s = ST_UNSYNC;
                match_next_s = 4'd0;
            end
        endcase
    end

    // Output decode: error/wrap events and next counter values
    always_comb begin
        error_event_s = 1'b0;
        wrap_event_s  = 1'b0;
        if (state_r == ST_LOCKED) begin
            error_event_s = ~hit_s;
            wrap_event_s  = hit_s & prev_en_r & (prev_r == VAL_MAX);
        end else begin
            error_event_s = 1'b0;
            wrap_event_s  = 1'b0;
        end

        // Clear takes priority over a coincident increment.
        error_count_next_s = error_count_r;
        if (clear_i) begin
            error_count_next_s = CNT_ZERO;
        end else if (error_event_s && (error_count_r != CNT_MAX)) begin
            error_count_next_s = error_count_r + CNT_ONE;
        end else begin
            error_count_next_s = error_count_r;
        end

        wrap_count_next_s = wrap_count_r;
        if (clear_i) begin
            wrap_count_next_s = CNT_ZERO;
        end else if (wrap_event_s) begin
            wrap_count_next_s = wrap_count_r + CNT_ONE;
        end else begin
            wrap_count_next_s = wrap_count_r;
        end
    end

    // Sample history and register all outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            prev_r        <= {WIDTH{1'b0}};
            prev_en_r     <= 1'b0;
            locked_r      <= 1'b0;
            error_r       <= 1'b0;
            error_count_r <= CNT_ZERO;
            wrap_count_r  <= CNT_ZERO;
        end else begin
            prev_r        <= counter_value_i;
            prev_en_r     <= enable_i;
            locked_r      <= (state_next_s == ST_LOCKED);
            error_r       <= error_event_s;
            error_count_r <= error_count_next_s;
            wrap_count_r  <= wrap_count_next_s;
        end
    end

    assign locked_o      = locked_r;
    assign error_o       = error_r;
    assign error_count_o = error_count_r;
    assign wrap_count_o  = wrap_count_r;

endmodule

// File: tb/tb_counter_monitor.sv
// Testbench for counter_monitor. Two instances share the same stimulus: one
// with the default 8-bit counters and one with 2-bit counters, so error-count
// saturation and wrap-count rollover get exercised. A behavioural model
// predicts the outputs after every edge and queues them. A separate monitor
// compares each queued prediction with the DUT outputs one time unit after
// the edge.

module tb_counter_monitor;

    localparam int W  = 4;
    localparam int LC = 3;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         enable_i;
    logic         clear_i;
    logic [W-1:0] counter_value_i;

    logic         locked_a, error_a;
    logic [7:0]   ec_a, wc_a;
    logic         locked_b, error_b;
    logic [1:0]   ec_b, wc_b;

    always #5 clock_i = ~clock_i;

    counter_monitor #(.WIDTH(W), .LOCK_CNT(LC), .CNT_W(8)) dut_a (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .counter_value_i(counter_value_i), .clear_i(clear_i),
        .locked_o(locked_a), .error_o(error_a),
        .error_count_o(ec_a), .wrap_count_o(wc_a)
    );

    counter_monitor #(.WIDTH(W), .LOCK_CNT(LC), .CNT_W(2)) dut_b (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .counter_value_i(counter_value_i), .clear_i(clear_i),
        .locked_o(locked_b), .error_o(error_b),
        .error_count_o(ec_b), .wrap_count_o(wc_b)
    );

    typedef struct packed {
        logic       locked;
        logic       error;
        logic [7:0] ec;
        logic [7:0] wc;
        logic [1:0] ec2;
        logic [1:0] wc2;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain integers following the checking rules.
    bit m_have_history;
    bit m_locked;
    int m_prev, m_prev_en, m_streak;
    int m_ec, m_wc, m_ec2, m_wc2;

    task automatic model_edge(input bit en, input int val, input bit clr, input bit rst);
        bit err, wrap, hit;
        obs_t o;
        err  = 1'b0;
        wrap = 1'b0;
        if (rst) begin
            m_have_history = 1'b0;
            m_locked = 1'b0;
            m_prev = 0; m_prev_en = 0; m_streak = 0;
            m_ec = 0; m_wc = 0; m_ec2 = 0; m_wc2 = 0;
        end else begin
            hit = (val == ((m_prev + m_prev_en) % 16));
            if (!m_have_history) begin
                m_have_history = 1'b1;
                m_streak = 0;
            end else if (m_locked) begin
                if (hit) begin
                    wrap = (m_prev_en == 1) && (m_prev == 15);
                end else begin
                    err = 1'b1;
                    m_locked = 1'b0;
                    m_streak = 0;
                end
            end else if (hit) begin
                m_streak++;
                if (m_streak == LC) begin
                    m_locked = 1'b1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            if (clr) begin
                m_ec = 0; m_wc = 0; m_ec2 = 0; m_wc2 = 0;
            end else begin
                if (err) begin
                    if (m_ec < 255) m_ec++;
                    if (m_ec2 < 3) m_ec2++;
                end
                if (wrap) begin
                    m_wc = (m_wc + 1) % 256;
                    m_wc2 = (m_wc2 + 1) % 4;
                end
            end
            m_prev = val;
            m_prev_en = en;
        end
        o.locked = m_locked;
        o.error  = err;
        o.ec     = 8'(m_ec);
        o.wc     = 8'(m_wc);
        o.ec2    = 2'(m_ec2);
        o.wc2    = 2'(m_wc2);
        exp_q.push_back(o);
    endtask

    // Drive one cycle of stimulus (called at a falling edge).
    task automatic step(input bit en, input logic [W-1:0] val, input bit clr, input bit rst);
        enable_i        = en;
        counter_value_i = val;
        clear_i         = clr;
        reset_i         = rst;
        @(posedge clock_i);
        model_edge(en, int'(val), clr, rst);
        @(negedge clock_i);
    endtask

    logic [W-1:0] v;

    // A well-behaved counter step: present v, then advance by en.
    task automatic good(input bit en, input bit clr);
        step(en, v, clr, 1'b0);
        v = v + W'(en);
    endtask

    // A corrupted step: present a value that cannot match.
    task automatic bad(input bit en, input bit clr);
        logic [W-1:0] b;
        b = v + W'($urandom_range(1, 15));
        step(en, b, clr, 1'b0);
        v = b + W'(en);
    endtask

    // Monitor: compare each prediction with both DUTs after the edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clock_i);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {locked_a, error_a, ec_a, wc_a, ec_b, wc_b};
                checks++;
                if (a !== e || locked_b !== e.locked || error_b !== e.error) begin
                    errors++;
                    $display("FAIL outputs t=%0t got lk=%b/%b er=%b/%b ec=%0d wc=%0d ec2=%0d wc2=%0d exp lk=%b er=%b ec=%0d wc=%0d ec2=%0d wc2=%0d",
                             $time, locked_a, locked_b, error_a, error_b, ec_a, wc_a, ec_b, wc_b,
                             e.locked, e.error, e.ec, e.wc, e.ec2, e.wc2);
                end
            end
        end
    end

    initial begin
        int r;
        bit en;
        reset_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; counter_value_i = '0;
        v = '0;

        // Reset, then free-run from 0: lock after 4th edge, wrap at 15->0.
        step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        v = 4'd0;
        repeat (20) good(1'b1, 1'b0);

        // Hold check while locked: 5 en1, 6 en0, 6 en0, 6 en1, 7.
        for (int i = 0; i < 16 && v != 4'd5; i++) good(1'b1, 1'b0);
        good(1'b1, 1'b0);
        good(1'b0, 1'b0);
        good(1'b0, 1'b0);
        good(1'b1, 1'b0);
        good(1'b1, 1'b0);

        // Glitch: 9 then 12 instead of 10, then relock.
        for (int i = 0; i < 16 && v != 4'd9; i++) good(1'b1, 1'b0);
        good(1'b1, 1'b0);
        step(1'b1, 4'd12, 1'b0, 1'b0);
        v = 4'd13;
        repeat (6) good(1'b1, 1'b0);

        // Clear coincident with a wrap while locked.
        for (int i = 0; i < 16 && v != 4'd15; i++) good(1'b1, 1'b0);
        good(1'b1, 1'b0);
        good(1'b1, 1'b1);
        repeat (3) good(1'b1, 1'b0);

        // Reset in the middle of LOCKED, then re-acquire.
        step(1'b1, v, 1'b0, 1'b1);
        v = v + 4'd1;
        repeat (10) good(1'b1, 1'b0);

        // Randomized traffic with glitches, clears and resets.
        repeat (3000) begin
            r  = $urandom_range(0, 199);
            en = 1'($urandom_range(0, 1));
            if (r < 10) begin
                bad(en, 1'b0);
            end else if (r < 12) begin
                step(en, v, 1'b0, 1'b1);
                v = v + W'(en);
            end else if (r < 15) begin
                good(en, 1'b1);
            end else if (r < 17) begin
                bad(en, 1'b1);
            end else begin
                good(en, 1'b0);
            end
        end

        @(posedge clock_i);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Receiving end of the counter board's `counter_value_o` / `enable_i` interface.
- Samples a WIDTH-bit up-counter value together with the enable that drives it, and checks that every cycle the value advances by exactly the sampled enable, modulo 2^WIDTH.
- Reports lock status, single-cycle error pulses, a saturating error count and a wrap count.
- Sits beside `counter_board` on the same clock as an on-chip self-checker.

Parameters:
- WIDTH, 4, width of the monitored counter value.
- LOCK_CNT, 3, number of consecutive correct steps needed to enter LOCKED (range 1..15).
- CNT_W, 8, width of the error and wrap counters.

Ports:
- clock_i  input  1  system clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- enable_i  input  1  enable seen by the monitored counter, sampled alongside the value.
- counter_value_i  input  WIDTH  monitored counter value.
- clear_i  input  1  synchronous clear of error_count_o and wrap_count_o only.
- locked_o  output  1  high while state is LOCKED.
- error_o  output  1  one-cycle pulse on a mismatch detected in LOCKED.
- error_count_o  output  CNT_W  number of LOCKED mismatches, saturating at all-ones.
- wrap_count_o  output  CNT_W  number of verified wraps from max to 0, wrapping modulo 2^CNT_W.

Behaviour:
- Registers:
  - prev_q: WIDTH bits, last sampled value.
  - prev_en_q: 1 bit, last sampled enable.
  - match_q: 4 bits, consecutive-match counter.
  - state: UNSYNC / ACQUIRE / LOCKED.
- Reset (reset_i=1 at an edge):
  - state=UNSYNC; prev_q=0, prev_en_q=0, match_q=0.
  - locked_o=0, error_o=0, error_count_o=0, wrap_count_o=0.
  - Reset mid-operation discards all history identically.
- Every non-reset edge: prev_q <= counter_value_i; prev_en_q <= enable_i.
- Expected value: exp = prev_q + prev_en_q, truncated to WIDTH bits. Comparison uses counter_value_i at the current edge; hit = (counter_value_i == exp).
- UNSYNC: unconditionally goes to ACQUIRE, match_q=0, no comparison. The first post-reset edge only captures history.
- ACQUIRE:
  - On hit: match_q++. If match_q+1 == LOCK_CNT, go to LOCKED and clear match_q.
  - On miss: match_q=0, stay in ACQUIRE, no error reported.
- LOCKED:
  - On hit: stay in LOCKED.
  - On miss: error_o=1 for exactly the following cycle; error_count_o increments unless already all-ones; go to ACQUIRE with match_q=0.
- Wrap: in LOCKED, a hit with prev_en_q=1 and prev_q == 2^WIDTH-1 (so counter_value_i == 0) increments wrap_count_o. Wraps seen in ACQUIRE are not counted.
- Output timing:
  - All outputs are registered and reflect the decision made at the sampling edge, visible in the cycle after it.
  - locked_o rises in the cycle after the LOCK_CNT-th consecutive hit.
  - locked_o falls in the same cycle error_o pulses.
- Hold check: enable 0 with an unchanged value is a hit. Any change while enable was 0 is a miss.
- clear_i=1 (without reset):
  - Zeroes error_count_o and wrap_count_o; state and history are unaffected.
  - If clear_i coincides with an increment event, clear wins: the counter becomes 0.
  - error_o is still generated normally.
- Simultaneous error and saturation: error_o still pulses; error_count_o holds all-ones.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then counter free-running with enable=1 from 0: locked_o=1 in the cycle after the 3rd checked step (4th post-reset edge). error_count_o=0 throughout.
- Locked, enable=1 through 14,15,0,1: wrap_count_o goes 0->1 the cycle after value 0 is sampled. error_o stays 0.
- Locked at value 5, enable toggling 1,0,0,1 with values 6,6,6,7: no error, locked_o stays 1.
- Locked at 9 with enable=1, inject value 12 instead of 10: error_o=1 for one cycle, error_count_o=1, locked_o=0. Relock after 3 good steps.
- CNT_W=2, force 4 LOCKED mismatches with relocks between: error_count_o reads 1,2,3,3. error_o pulses all 4 times.
- clear_i asserted in the same cycle as a wrap: wrap_count_o=0 next cycle, locked_o unaffected. Then reset_i asserted mid-LOCKED: all outputs 0 next cycle, state re-acquires.
